conv_window_sequencer: RTL and testbench

Sequencer for the on-chip feature-map/weight memory. On `start`, it walks a stride-1, no-padding 3×3 window over the stored fmap and issues the nine tap addresses plus the weight-set `step` each cycle. It tags the memory's registered outputs with a valid/ready handshake toward the PE array and signals completion. It sits between the top-level control FSM and the memory, and drives its `readi_w`, `readi_h` and `step` inputs.

---
 rtl/conv_window_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//
// Walks a stride-1, no-padding 3x3 window over the feature map held in the
// on-chip fmap/weight memory. Each cycle it drives nine tap addresses and the
// weight-set select. It also tags the memory's registered read data with a
// valid/ready handshake toward the PE array.
//
// Ports
//   clk, reset_n           : clock (rising edge), synchronous active-low reset
//   start                  : run request, sampled only while idle
//   cfg_fmap_w/h, cfg_steps: run geometry, latched when start is accepted
//   busy / done / cfg_err  : run in progress / last beat taken / start rejected
//   readi_w, readi_h, step : memory read addresses (tap0 in the MSBs) and weight set
//   out_valid, out_ready   : handshake for the beat at the memory output
//   out_x, out_y, out_step : window origin and weight set of the current beat
//   out_last               : current beat is the final one of the run
module conv_window_sequencer #(
  parameter int width     = 80,
  parameter int height    = 8,
  parameter int width_b   = 7,
  parameter int height_b  = 3,
  parameter int max_steps = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [width_b-1:0]      cfg_fmap_w,
  input  logic [height_b:0]       cfg_fmap_h,
  input  logic [2:0]              cfg_steps,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [width_b*9-1:0]    readi_w,
  output logic [height_b*9-1:0]   readi_h,
  output logic [2:0]              step,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [width_b-1:0]      out_x,
  output logic [height_b-1:0]     out_y,
  output logic [2:0]              out_step,
  output logic                    out_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [width_b-1:0]  W_THREE = 3;
  localparam logic [width_b-1:0]  W_ONE   = 1;
  localparam logic [height_b:0]   H_THREE = 3;
  localparam logic [height_b-1:0] H_ONE   = 1;

  state_t                state_q, state_d;
  // Last window origin / weight set of the latched run geometry
  logic [width_b-1:0]    wmax_q, wmax_d;
  logic [height_b-1:0]   hmax_q, hmax_d;
  logic [2:0]            smax_q, smax_d;
  // Coordinate being issued to the memory this cycle
  logic [width_b-1:0]    cur_x_q, cur_x_d;
  logic [height_b-1:0]   cur_y_q, cur_y_d;
  logic [2:0]            cur_s_q, cur_s_d;
  // Coordinate whose data currently sits at the memory output
  logic [width_b-1:0]    prev_x_q, prev_x_d;
  logic [height_b-1:0]   prev_y_q, prev_y_d;
  logic [2:0]            prev_s_q, prev_s_d;
  logic                  prev_last_q, prev_last_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  stall;
  logic                  cfg_ok;
  logic                  cur_last;
  logic [width_b-1:0]    sel_x;
  logic [height_b-1:0]   sel_y;
  logic [2:0]            sel_s;

  assign stall    = valid_q & ~out_ready;
  assign cur_last = (cur_s_q == smax_q) && (cur_x_q == wmax_q) && (cur_y_q == hmax_q);

  // Geometry check: the fmap must leave room for 9 weight columns per weight set.
  always_comb begin
    int lim;
    lim    = width - 9 * int'(cfg_steps);
    cfg_ok = (int'(cfg_fmap_w) >= 3) && (int'(cfg_fmap_w) <= lim) &&
             (int'(cfg_fmap_h) >= 3) && (int'(cfg_fmap_h) <= height) &&
             (cfg_steps != 3'd0) && (int'(cfg_steps) <= max_steps);
  end

  always_comb begin
    state_d     = state_q;
    wmax_d      = wmax_q;
    hmax_d      = hmax_q;
    smax_d      = smax_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    cur_s_d     = cur_s_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    prev_s_d    = prev_s_q;
    prev_last_d = prev_last_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d = RUN;
            wmax_d  = cfg_fmap_w - W_THREE;
            hmax_d  = height_b'(cfg_fmap_h - H_THREE);
            smax_d  = cfg_steps - 3'd1;
            cur_x_d = '0;
            cur_y_d = '0;
            cur_s_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (!stall) begin
          prev_x_d    = cur_x_q;
          prev_y_d    = cur_y_q;
          prev_s_d    = cur_s_q;
          prev_last_d = cur_last;
          valid_d     = 1'b1;
          if (cur_last) begin
            state_d = DRAIN;
          end else if (cur_s_q != smax_q) begin
            cur_s_d = cur_s_q + 3'd1;
          end else begin
            // Weight sets innermost, then columns, then rows
            cur_s_d = '0;
            if (cur_x_q != wmax_q) begin
              cur_x_d = cur_x_q + W_ONE;
            end else begin
              cur_x_d = '0;
              cur_y_d = cur_y_q + H_ONE;
            end
          end
        end
      end

      DRAIN: begin
        // Only the final beat is outstanding here; once it is taken the
        // coordinate registers return to their idle values.
        if (valid_q && out_ready) begin
          state_d     = IDLE;
          valid_d     = 1'b0;
          done_d      = 1'b1;
          cur_x_d     = '0;
          cur_y_d     = '0;
          cur_s_d     = '0;
          prev_x_d    = '0;
          prev_y_d    = '0;
          prev_s_d    = '0;
          prev_last_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wmax_q      <= '0;
      hmax_q      <= '0;
      smax_q      <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      cur_s_q     <= '0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
      prev_s_q    <= '0;
      prev_last_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wmax_q      <= wmax_d;
      hmax_q      <= hmax_d;
      smax_q      <= smax_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cur_s_q     <= cur_s_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      prev_s_q    <= prev_s_d;
      prev_last_q <= prev_last_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // On a stall the previous coordinate is re-read so the memory output
  // keeps presenting the same beat on the next cycle.
  assign sel_x = stall ? prev_x_q : cur_x_q;
  assign sel_y = stall ? prev_y_q : cur_y_q;
  assign sel_s = stall ? prev_s_q : cur_s_q;

  always_comb begin
    readi_w = '0;
    readi_h = '0;
    step    = '0;
    if (state_q != IDLE) begin
      step = sel_s;
      for (int k = 0; k < 9; k++) begin
        readi_w[(8-k)*width_b +: width_b]   = sel_x + width_b'(k % 3);
        readi_h[(8-k)*height_b +: height_b] = sel_y + height_b'(k / 3);
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign cfg_err   = err_q;
  assign out_valid = valid_q;
  assign out_x     = prev_x_q;
  assign out_y     = prev_y_q;
  assign out_step  = prev_s_q;
  assign out_last  = prev_last_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
module tb_conv_window_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [6:0]  cfg_fmap_w = '0;
  logic [3:0]  cfg_fmap_h = '0;
  logic [2:0]  cfg_steps = '0;
  logic        busy, done, cfg_err, out_valid, out_last;
  logic [62:0] readi_w;
  logic [26:0] readi_h;
  logic [2:0]  step, out_step;
  logic [6:0]  out_x;
  logic [2:0]  out_y;

  int checks = 0;
  int failures = 0;

  conv_window_sequencer #(
    .width(80), .height(8), .width_b(7), .height_b(3), .max_steps(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_fmap_w(cfg_fmap_w), .cfg_fmap_h(cfg_fmap_h), .cfg_steps(cfg_steps),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .readi_w(readi_w), .readi_h(readi_h), .step(step),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_step(out_step), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Registered memory model: each tap returns its own address.
  logic [62:0] mem_w;
  logic [26:0] mem_h;
  logic [2:0]  mem_s;
  always @(posedge clk) begin
    mem_w <= readi_w;
    mem_h <= readi_h;
    mem_s <= step;
  end

  function automatic logic [62:0] taps_w(input int x);
    logic [62:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[(8-k)*7 +: 7] = 7'(x + k % 3);
    return v;
  endfunction

  function automatic logic [26:0] taps_h(input int y);
    logic [26:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[(8-k)*3 +: 3] = 3'(y + k / 3);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for first 3 valid cycles
  task automatic run_frame(input int w, input int h, input int s, input int mode, input bit poke,
                           output int beats, output int first_cyc, output int last_cyc,
                           output int done_cyc, output int seq_err, output int lx, output int ly,
                           output int ls, output bit busy1, output bit idle_at_done);
    int total, ex, ey, es, cyc, vcnt;
    total = (w - 2) * (h - 2) * s;
    beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; seq_err = 0;
    lx = -1; ly = -1; ls = -1; idle_at_done = 1'b0;
    ex = 0; ey = 0; es = 0; vcnt = 0;
    cfg_fmap_w = 7'(w); cfg_fmap_h = 4'(h); cfg_steps = 3'(s);
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    busy1 = busy && (readi_w == taps_w(0)) && (readi_h == taps_h(0)) && (step == 3'd0);
    while (cyc < total * 6 + 20) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (vcnt >= 3);
      endcase
      if (poke) begin
        start = (cyc == 4);
        if (cyc == 4) begin
          cfg_fmap_w = 7'd3; cfg_fmap_h = 4'd3; cfg_steps = 3'd1;
        end
      end
      #1;
      if (out_valid) begin
        vcnt++;
        if (first_cyc < 0) first_cyc = cyc;
        if (out_x !== 7'(ex) || out_y !== 3'(ey) || out_step !== 3'(es) ||
            mem_w !== taps_w(ex) || mem_h !== taps_h(ey) || mem_s !== 3'(es) ||
            out_last !== (beats == total - 1) || beats >= total)
          seq_err++;
        if (out_ready) begin
          beats++;
          last_cyc = cyc;
          lx = int'(out_x); ly = int'(out_y); ls = int'(out_step);
          es++;
          if (es == s) begin
            es = 0; ex++;
            if (ex == w - 2) begin ex = 0; ey++; end
          end
        end
      end
      if (done) begin
        done_cyc = cyc;
        idle_at_done = !busy && !out_valid;
        break;
      end
      tick;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick; tick; tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got busy=%b done=%b cfg_err=%b out_valid=%b expected all 0", busy, done, cfg_err, out_valid);
    end
    checks++;
    if (readi_w !== 63'd0 || readi_h !== 27'd0 || step !== 3'd0) begin
      failures++;
      $display("FAIL reset_addr: got readi_w=%h readi_h=%h step=%0d expected 0", readi_w, readi_h, step);
    end
    checks++;
    if (out_x !== 7'd0 || out_y !== 3'd0 || out_step !== 3'd0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_out: got x=%0d y=%0d s=%0d last=%b expected 0", out_x, out_y, out_step, out_last);
    end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int b, f, l, d, e, lx, ly, ls;
    bit b1, id;
    run_frame(4, 4, 2, 0, 1'b0, b, f, l, d, e, lx, ly, ls, b1, id);
    checks++;
    if (b != 8) begin failures++; $display("FAIL basic_beats: got %0d expected 8", b); end
    checks++;
    if (f != 2 || l != 9) begin failures++; $display("FAIL basic_cycles: got first=%0d last=%0d expected 2 and 9", f, l); end
    checks++;
    if (d != 10) begin failures++; $display("FAIL basic_done: got cycle %0d expected 10", d); end
    checks++;
    if (e != 0) begin failures++; $display("FAIL basic_seq: got %0d bad beats expected 0", e); end
    checks++;
    if (!b1) begin failures++; $display("FAIL basic_cycle1: got busy/first address wrong expected busy=1 at (0,0,0)"); end
    checks++;
    if (!id) begin failures++; $display("FAIL basic_idle: got busy or out_valid high at done expected both 0"); end
  endtask

  task automatic test_backpressure;
    int b, f, l, d, e, lx, ly, ls;
    bit b1, id;
    run_frame(5, 3, 3, 1, 1'b0, b, f, l, d, e, lx, ly, ls, b1, id);
    checks++;
    if (b != 9) begin failures++; $display("FAIL bp_beats: got %0d expected 9", b); end
    checks++;
    if (e != 0) begin failures++; $display("FAIL bp_seq: got %0d bad beats expected 0", e); end
    checks++;
    if (d != l + 1) begin failures++; $display("FAIL bp_done: got cycle %0d expected %0d", d, l + 1); end
  endtask

  task automatic test_cfg_err;
    int tw[7] = '{2, 27, 72, 4, 4, 4, 4};
    int th[7] = '{4, 8, 3, 9, 2, 4, 4};
    int ts[7] = '{1, 6, 1, 1, 1, 0, 7};
    int b, f, l, d, e, lx, ly, ls;
    bit b1, id;
    for (int i = 0; i < 7; i++) begin
      cfg_fmap_w = 7'(tw[i]); cfg_fmap_h = 4'(th[i]); cfg_steps = 3'(ts[i]);
      start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err_%0d: got cfg_err=%b busy=%b expected 1 and 0 (w=%0d h=%0d s=%0d)", i, cfg_err, busy, tw[i], th[i], ts[i]);
      end
      tick;
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err_pulse_%0d: got cfg_err=%b busy=%b expected 0 and 0", i, cfg_err, busy);
      end
    end
    run_frame(26, 3, 6, 0, 1'b0, b, f, l, d, e, lx, ly, ls, b1, id);
    checks++;
    if (b != 144 || e != 0 || d != l + 1) begin
      failures++;
      $display("FAIL cfg_w26s6: got beats=%0d bad=%0d done=%0d expected 144, 0, %0d", b, e, d, l + 1);
    end
    run_frame(71, 3, 1, 0, 1'b0, b, f, l, d, e, lx, ly, ls, b1, id);
    checks++;
    if (b != 69 || e != 0 || d != l + 1) begin
      failures++;
      $display("FAIL cfg_w71s1: got beats=%0d bad=%0d done=%0d expected 69, 0, %0d", b, e, d, l + 1);
    end
  endtask

  task automatic test_min_fmap;
    int b, f, l, d, e, lx, ly, ls;
    bit b1, id;
    run_frame(3, 3, 1, 2, 1'b0, b, f, l, d, e, lx, ly, ls, b1, id);
    checks++;
    if (b != 1 || e != 0) begin failures++; $display("FAIL min_beat: got beats=%0d bad=%0d expected 1 and 0", b, e); end
    checks++;
    if (f != 2 || l != 5 || d != 6) begin
      failures++;
      $display("FAIL min_timing: got first=%0d accept=%0d done=%0d expected 2, 5, 6", f, l, d);
    end
  endtask

  task automatic test_start_in_run;
    int b, f, l, d, e, lx, ly, ls;
    bit b1, id;
    run_frame(4, 4, 2, 0, 1'b1, b, f, l, d, e, lx, ly, ls, b1, id);
    checks++;
    if (b != 8 || e != 0 || d != 10) begin
      failures++;
      $display("FAIL start_in_run: got beats=%0d bad=%0d done=%0d expected 8, 0, 10", b, e, d);
    end
  endtask

  task automatic test_reset_midrun;
    int beats, b, f, l, d, e, lx, ly, ls, seen_done;
    bit b1, id;
    beats = 0;
    cfg_fmap_w = 7'd4; cfg_fmap_h = 4'd4; cfg_steps = 3'd2;
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      if (out_valid) beats++;
      if (beats < 3) tick;
    end
    checks++;
    if (beats != 3) begin failures++; $display("FAIL midrun_beats: got %0d expected 3", beats); end
    reset_n = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || readi_w !== 63'd0 || readi_h !== 27'd0 ||
        step !== 3'd0 || out_x !== 7'd0 || out_y !== 3'd0 || out_step !== 3'd0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: got busy=%b valid=%b done=%b x=%0d y=%0d s=%0d readi_w=%h expected all 0",
               busy, out_valid, done, out_x, out_y, out_step, readi_w);
    end
    reset_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (done) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin failures++; $display("FAIL midrun_no_done: got %0d done pulses expected 0", seen_done); end
    out_ready = 1'b0;
    run_frame(3, 4, 2, 0, 1'b0, b, f, l, d, e, lx, ly, ls, b1, id);
    checks++;
    if (b != 4 || e != 0 || f != 2 || d != l + 1) begin
      failures++;
      $display("FAIL midrun_restart: got beats=%0d bad=%0d first=%0d done=%0d expected 4, 0, 2, %0d", b, e, f, d, l + 1);
    end
  endtask

  task automatic test_max;
    int b, f, l, d, e, lx, ly, ls;
    bit b1, id;
    run_frame(26, 8, 6, 0, 1'b0, b, f, l, d, e, lx, ly, ls, b1, id);
    checks++;
    if (b != 864 || e != 0) begin failures++; $display("FAIL max_beats: got beats=%0d bad=%0d expected 864 and 0", b, e); end
    checks++;
    if (lx != 23 || ly != 5 || ls != 5) begin
      failures++;
      $display("FAIL max_last: got (%0d,%0d,%0d) expected (23,5,5)", lx, ly, ls);
    end
    checks++;
    if (d != l + 1 || l != 865) begin
      failures++;
      $display("FAIL max_done: got last=%0d done=%0d expected 865 and 866", l, d);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_cfg_err;
    test_min_fmap;
    test_start_in_run;
    test_reset_midrun;
    test_max;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
